// File: rtl/regfile_scoreboard.sv
// 32x32 integer register file with a per-register busy-bit scoreboard that raises the decode stall.
// Optional macro REGFILE_BYPASS_EN: write-through reads and bypass-aware hazard checks.
module regfile_scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int XLEN     = 32,
  localparam int AW      = $clog2(NUM_REGS)
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic [AW-1:0]       rs1_addr_i,
  input  logic [AW-1:0]       rs2_addr_i,
  input  logic                rs1_used_i,
  input  logic                rs2_used_i,
  input  logic                issue_i,
  input  logic [AW-1:0]       issue_rd_i,
  input  logic                issue_wr_i,
  input  logic                wr_en_i,
  input  logic [AW-1:0]       wr_addr_i,
  input  logic [XLEN-1:0]     wr_data_i,
  output logic [XLEN-1:0]     reg1_data_o,
  output logic [XLEN-1:0]     reg2_data_o,
  output logic                stall_o,
  output logic [NUM_REGS-1:0] busy_o
);

  logic [XLEN-1:0]     regs_reg [NUM_REGS];
  logic [NUM_REGS-1:0] busy_reg;
  logic [NUM_REGS-1:0] busy_next;
  logic                byp1, byp2, bypw;
  logic                h1, h2, hw;
  logic                accept;

  // x0 is never written, so it holds its reset value of zero forever.
  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_regs
    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        regs_reg[gi] <= '0;
      end else if (wr_en_i && (wr_addr_i == AW'(gi)) && (gi != 0)) begin
        regs_reg[gi] <= wr_data_i;
      end
    end
  end

`ifdef REGFILE_BYPASS_EN
  // Write-back value forwards in the same cycle; reset forces the bypass off.
  always_comb begin
    byp1 = rst_n_i && wr_en_i && (wr_addr_i == rs1_addr_i);
    byp2 = rst_n_i && wr_en_i && (wr_addr_i == rs2_addr_i);
    bypw = rst_n_i && wr_en_i && (wr_addr_i == issue_rd_i);
    if (rs1_addr_i == '0)  reg1_data_o = '0;
    else if (byp1)         reg1_data_o = wr_data_i;
    else                   reg1_data_o = regs_reg[rs1_addr_i];
    if (rs2_addr_i == '0)  reg2_data_o = '0;
    else if (byp2)         reg2_data_o = wr_data_i;
    else                   reg2_data_o = regs_reg[rs2_addr_i];
  end
`else
  always_comb begin
    byp1        = 1'b0;
    byp2        = 1'b0;
    bypw        = 1'b0;
    reg1_data_o = regs_reg[rs1_addr_i];
    reg2_data_o = regs_reg[rs2_addr_i];
  end
`endif

  always_comb begin
    h1      = rs1_used_i && busy_reg[rs1_addr_i] && !byp1;
    h2      = rs2_used_i && busy_reg[rs2_addr_i] && !byp2;
    hw      = issue_wr_i && busy_reg[issue_rd_i] && !bypw;
    stall_o = issue_i && (h1 || h2 || hw);
    accept  = issue_i && !stall_o;
  end

  // Set beats clear: the newly issued instruction owns the register.
  always_comb begin
    busy_next = busy_reg;
    for (int r = 1; r < NUM_REGS; r++) begin
      if (accept && issue_wr_i && (issue_rd_i == AW'(r)))
        busy_next[r] = 1'b1;
      else if (wr_en_i && (wr_addr_i == AW'(r)))
        busy_next[r] = 1'b0;
    end
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) busy_reg <= '0;
    else          busy_reg <= busy_next;
  end

  assign busy_o = busy_reg;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard: directed scenarios then random traffic against a rule-level model.
module tb_regfile_scoreboard;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic [4:0]  rs1_addr_i, rs2_addr_i, issue_rd_i, wr_addr_i;
  logic        rs1_used_i, rs2_used_i, issue_i, issue_wr_i, wr_en_i;
  logic [31:0] wr_data_i;
  logic [31:0] reg1_data_o, reg2_data_o, busy_o;
  logic        stall_o;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] m_regs [32];
  bit          m_busy [32];

  regfile_scoreboard dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i),
    .rs1_used_i(rs1_used_i), .rs2_used_i(rs2_used_i),
    .issue_i(issue_i), .issue_rd_i(issue_rd_i), .issue_wr_i(issue_wr_i),
    .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i),
    .reg1_data_o(reg1_data_o), .reg2_data_o(reg2_data_o),
    .stall_o(stall_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit bypassing(input logic [4:0] a);
`ifdef REGFILE_BYPASS_EN
    return wr_en_i && wr_addr_i == a;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 0) return 32'h0;
    if (bypassing(a)) return wr_data_i;
    return m_regs[a];
  endfunction

  function automatic bit m_stall();
    return issue_i && ((rs1_used_i && m_busy[rs1_addr_i] && !bypassing(rs1_addr_i)) ||
                       (rs2_used_i && m_busy[rs2_addr_i] && !bypassing(rs2_addr_i)) ||
                       (issue_wr_i && m_busy[issue_rd_i] && !bypassing(issue_rd_i)));
  endfunction

  function automatic logic [31:0] m_busy_vec();
    logic [31:0] v = '0;
    for (int i = 0; i < 32; i++) v[i] = m_busy[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = '0;
      m_busy[i] = 1'b0;
    end
  endtask

  task automatic idle();
    rs1_addr_i = 0; rs2_addr_i = 0; rs1_used_i = 0; rs2_used_i = 0;
    issue_i = 0; issue_rd_i = 0; issue_wr_i = 0;
    wr_en_i = 0; wr_addr_i = 0; wr_data_i = 0;
  endtask

  // Compare all outputs with the model on the falling edge.
  task automatic settle();
    @(negedge clk_i);
    chk("reg1", reg1_data_o, m_read(rs1_addr_i));
    chk("reg2", reg2_data_o, m_read(rs2_addr_i));
    chk("stall", {31'b0, stall_o}, {31'b0, m_stall()});
    chk("busy", busy_o, m_busy_vec());
  endtask

  // Advance the model with the architectural rules at the rising edge.
  task automatic tick();
    bit acc;
    acc = issue_i && !m_stall();
    @(posedge clk_i);
    if (!rst_n_i) begin
      model_reset();
    end else begin
      if (wr_en_i && wr_addr_i != 0) m_regs[wr_addr_i] = wr_data_i;
      if (wr_en_i) m_busy[wr_addr_i] = 1'b0;
      if (acc && issue_wr_i && issue_rd_i != 0) m_busy[issue_rd_i] = 1'b1;
    end
    #1;
  endtask

  task automatic do_issue(input logic [4:0] rd);
    idle(); issue_i = 1; issue_wr_i = 1; issue_rd_i = rd;
    settle(); tick();
  endtask

  task automatic do_write(input logic [4:0] a, input logic [31:0] d);
    idle(); wr_en_i = 1; wr_addr_i = a; wr_data_i = d;
    settle(); tick();
  endtask

  initial begin
    model_reset();
    idle();
    rst_n_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    settle();
    chk("reset_busy", busy_o, 32'h0);
    rst_n_i = 1'b1;
    tick();

    // Basic write then read
    do_write(5'd5, 32'hDEADBEEF);
    idle(); rs1_addr_i = 5; rs2_addr_i = 0;
    settle();
    chk("x5_read", reg1_data_o, 32'hDEADBEEF);
    chk("x0_read", reg2_data_o, 32'h0);
    tick();

    // x0 ignores writes and is never marked busy
    do_write(5'd0, 32'h12345678);
    idle(); rs1_addr_i = 0;
    settle();
    chk("x0_after_wr", reg1_data_o, 32'h0);
    tick();
    do_issue(5'd0);
    idle(); settle();
    chk("x0_not_busy", busy_o, 32'h0);
    tick();

    // RAW on x7 resolved by write-back
    do_issue(5'd7);
    idle(); issue_i = 1; rs1_addr_i = 7; rs1_used_i = 1;
    settle();
    chk("raw_stall", {31'b0, stall_o}, 32'h1);
    chk("raw_busy7", busy_o, 32'h80);
    tick();
    wr_en_i = 1; wr_addr_i = 7; wr_data_i = 32'hA5A5A5A5;
    settle();
`ifdef REGFILE_BYPASS_EN
    chk("wb_cycle_stall", {31'b0, stall_o}, 32'h0);
    chk("wb_cycle_data", reg1_data_o, 32'hA5A5A5A5);
`else
    chk("wb_cycle_stall", {31'b0, stall_o}, 32'h1);
`endif
    tick();
    wr_en_i = 0;
    settle();
    chk("post_wb_stall", {31'b0, stall_o}, 32'h0);
    chk("post_wb_data", reg1_data_o, 32'hA5A5A5A5);
    tick();

    // Same-cycle write-back and re-issue of x3
    do_issue(5'd3);
    idle(); issue_i = 1; issue_wr_i = 1; issue_rd_i = 3;
    wr_en_i = 1; wr_addr_i = 3; wr_data_i = 32'h33;
    settle();
`ifdef REGFILE_BYPASS_EN
    chk("waw_wb_stall", {31'b0, stall_o}, 32'h0);
`else
    chk("waw_wb_stall", {31'b0, stall_o}, 32'h1);
`endif
    tick();
    idle(); settle();
`ifdef REGFILE_BYPASS_EN
    chk("waw_busy3", busy_o, 32'h8);
    tick();
    do_write(5'd3, 32'h44);
`else
    chk("waw_busy3", busy_o, 32'h0);
    tick();
`endif

    // WAW stall with nothing in flight to clear it
    do_issue(5'd9);
    idle(); issue_i = 1; issue_wr_i = 1; issue_rd_i = 9;
    settle();
    chk("waw9_stall", {31'b0, stall_o}, 32'h1);
    tick();
    idle(); settle();
    chk("waw9_busy", busy_o, 32'h200);
    tick();
    do_write(5'd9, 32'h99);

    // Asynchronous reset while x7 and x10 are busy
    do_issue(5'd7);
    do_issue(5'd10);
    idle(); issue_i = 1; rs1_addr_i = 7; rs1_used_i = 1; rs2_addr_i = 5; rs2_used_i = 1;
    settle();
    chk("pre_rst_busy", busy_o, 32'h480);
    #2 rst_n_i = 1'b0;
    #1;
    chk("arst_busy", busy_o, 32'h0);
    chk("arst_stall", {31'b0, stall_o}, 32'h0);
    chk("arst_reg1", reg1_data_o, 32'h0);
    chk("arst_reg2", reg2_data_o, 32'h0);
    model_reset();
    @(posedge clk_i);
    #1;
    rst_n_i = 1'b1;
    idle();

    // Random traffic; write-backs lean towards registers that are busy
    for (int n = 0; n < 400; n++) begin
      int s;
      rs1_addr_i = 5'($urandom_range(0, 31));
      rs2_addr_i = 5'($urandom_range(0, 31));
      rs1_used_i = 1'($urandom);
      rs2_used_i = 1'($urandom);
      issue_i    = 1'($urandom);
      issue_wr_i = 1'($urandom);
      issue_rd_i = 5'($urandom_range(0, 31));
      wr_en_i    = ($urandom_range(0, 2) != 0);
      wr_data_i  = $urandom;
      s = $urandom_range(0, 31);
      wr_addr_i  = 5'(s);
      if ($urandom_range(0, 3) != 0) begin
        for (int k = 0; k < 32; k++) begin
          if (m_busy[(s + k) % 32]) begin
            wr_addr_i = 5'((s + k) % 32);
            break;
          end
        end
      end
      settle();
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- 32x32 integer register file with an integrated busy-bit scoreboard. It sits directly upstream of the execute-operand capture stage.
- Drives reg1_data_o and reg2_data_o, which feed that stage's reg1_data/reg2_data operand muxes.
- Consumes the write-back value produced by the write-back mux.
- Generates the decode stall when a source or destination register has a write still in flight.

Parameters:
- NUM_REGS, 32, number of architectural registers; address width is $clog2(NUM_REGS).
- XLEN, 32, register data width.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_n_i  input  1  reset, asynchronous, active-low.
- rs1_addr_i  input  5  source 1 register address.
- rs2_addr_i  input  5  source 2 register address.
- rs1_used_i  input  1  instruction in decode reads rs1.
- rs2_used_i  input  1  instruction in decode reads rs2.
- issue_i  input  1  decode requests issue of the instruction.
- issue_rd_i  input  5  destination register of the issuing instruction.
- issue_wr_i  input  1  issuing instruction writes rd.
- wr_en_i  input  1  write-back enable.
- wr_addr_i  input  5  write-back register address.
- wr_data_i  input  32  write-back data, from the write-back mux.
- reg1_data_o  output  32  rs1 read data.
- reg2_data_o  output  32  rs2 read data.
- stall_o  output  1  decode must hold; issue is not accepted.
- busy_o  output  32  scoreboard busy vector, for debug and verification.

Behaviour:
- Reset (asynchronous, rst_n_i low):
  - All registers clear to 0.
  - busy_o = 0.
  - stall_o = 0.
  - reg1_data_o and reg2_data_o = 0.
  - Reset mid-operation discards all pending busy bits immediately.
- Register x0:
  - Reads return 0.
  - Writes to x0 are ignored.
  - busy[0] is never set.
- Write: on the rising edge with wr_en_i=1 and wr_addr_i!=0, regs[wr_addr_i] <= wr_data_i.
- Read: combinational on rs1_addr_i and rs2_addr_i; zero added latency.
- Scoreboard, per register r, evaluated at the rising edge:
  - clr_r = wr_en_i && wr_addr_i==r.
  - set_r = issue_i && !stall_o && issue_wr_i && issue_rd_i==r && r!=0.
  - busy[r] <= set_r ? 1 : (clr_r ? 0 : busy[r]).
  - Simultaneous set and clear on the same register: set wins, because the newer instruction now owns the register.
- Hazard terms:
  - h1 = rs1_used_i && busy[rs1_addr_i] && !byp1.
  - h2 = rs2_used_i && busy[rs2_addr_i] && !byp2.
  - hw = issue_wr_i && busy[issue_rd_i] && !bypw. This is the WAW check.
  - byp1, byp2 and bypw are defined under Optional Feature.
- stall_o = issue_i && (h1 || h2 || hw). It is combinational.
- Issue is accepted only in a cycle where issue_i=1 and stall_o=0.
- A write-back to a non-busy register is legal. It updates the data and leaves busy at 0.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - Read data is write-through. If wr_en_i=1, wr_addr_i==rsN_addr_i and the address is non-zero, regN_data_o = wr_data_i in the same cycle.
  - byp1 = wr_en_i && wr_addr_i==rs1_addr_i. byp2 and bypw are formed the same way against rs2_addr_i and issue_rd_i.
  - A dependent instruction therefore issues in the write-back cycle itself.
- Undefined:
  - byp1, byp2 and bypw are all 0.
  - Reads return stored contents only.
  - A dependent instruction stalls through the write-back cycle and issues the following cycle.

Test Plan:
- Reset, then write x5=0xDEADBEEF; next cycle read rs1=5 and rs2=0 -> reg1_data_o=0xDEADBEEF, reg2_data_o=0.
- Write x0=0x12345678, then read rs1=0 -> 0; busy_o stays 0 after an issue with rd=0.
- Issue rd=7 (accepted); next cycle decode has rs1=7, rs1_used=1 -> stall_o=1, busy_o[7]=1.
  - Then write-back x7=0xA5A5A5A5.
  - With REGFILE_BYPASS_EN: stall_o=0 in the write-back cycle and reg1_data_o=0xA5A5A5A5 that cycle.
  - Without it: stall_o=1 in the write-back cycle, and 0 with data valid the cycle after.
- Same-cycle write-back of x3 and issue with rd=3 -> busy_o[3] stays 1; with the bypass macro undefined the issue is stalled by the WAW check and busy_o[3] clears.
- Issue rd=9 while busy[9]=1 and no write-back pending -> stall_o=1, busy vector unchanged.
- Assert rst_n_i low mid-cycle while busy_o=0x00000480 -> busy_o=0, stall_o=0 and all reads 0 immediately, without waiting for a clock edge.
